iex_multicycle: RTL and testbench

Parametrised next-generation execute stage: single-cycle ALU/shift/address ops plus iterative multiply and divide (signed or unsigned) that stall the upstream pipeline while they run. Sits between decode/register-read and memory stage. Uses the same Control word encoding as the current execute stage, and adds valid/stall handshaking and a HI output for product high half or remainder.

---
 rtl/iex_multicycle_if.sv | 35 +++
 rtl/iex_multicycle.sv | 226 ++++++++++++++++++++++
 tb/tb_iex_multicycle.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/iex_multicycle_if.sv
// Execute-stage bus: issue side (InValid, operands, Control) and
// result side (Stall, OutValid, Result/HiOut, registered controls).
interface iex_multicycle_if #(
   parameter int WIDTH = 32,
   parameter int SAW   = 5
);
   logic             InValid;
   logic [WIDTH-1:0] Op1;
   logic [WIDTH-1:0] Op2;
   logic [SAW-1:0]   SA;
   logic [4:0]       DstIn;
   logic [WIDTH-1:0] StoreValIn;
   logic [31:0]      Control;
   logic             Stall;
   logic             OutValid;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] HiOut;
   logic [4:0]       DstOut;
   logic             WriteBack;
   logic [WIDTH-1:0] ExStoreValOut;
   logic             isMemRead;
   logic             isMemWrite;

   modport master (
      output InValid, Op1, Op2, SA, DstIn, StoreValIn, Control,
      input  Stall, OutValid, Result, HiOut, DstOut, WriteBack,
      input  ExStoreValOut, isMemRead, isMemWrite
   );

   modport slave (
      input  InValid, Op1, Op2, SA, DstIn, StoreValIn, Control,
      output Stall, OutValid, Result, HiOut, DstOut, WriteBack,
      output ExStoreValOut, isMemRead, isMemWrite
   );
endinterface

// File: rtl/iex_multicycle.sv
// Execute stage: 1-cycle ALU/shift/address ops, iterative mul/div.
// Ports: Clk, Reset (sync, active-high), bus (slave side of the bus).
module iex_multicycle #(
   parameter int WIDTH = 32,
   parameter int SAW   = 5,
   parameter int IMMW  = 16
) (
   input logic             Clk,
   input logic             Reset,
   iex_multicycle_if.slave bus
);
   localparam int W = WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t         state_q, state_d;
   logic [SAW-1:0] cnt_q, cnt_d;
   // lo: multiplier bits / dividend shifting into quotient
   // hi: partial product high half / partial remainder
   logic [W-1:0]   lo_q, lo_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   opb_q, opb_d;
   logic           is_div_q, is_div_d;
   logic           neg_q, neg_d;
   logic           negr_q, negr_d;
   logic           dz_q, dz_d;
   logic           wb_q, wb_d;
   logic [4:0]     dst_q, dst_d;
   logic [W-1:0]   sv_q, sv_d;

   logic           ov_q, ov_d;
   logic [W-1:0]   res_q, res_d;
   logic [W-1:0]   hio_q, hio_d;
   logic [4:0]     dsto_q, dsto_d;
   logic           wbo_q, wbo_d;
   logic [W-1:0]   svo_q, svo_d;
   logic           mr_q, mr_d;
   logic           mw_q, mw_d;

   logic [31:0]    c;
   logic           s1, s2;
   logic [W-1:0]   abs1, abs2;
   logic [W-1:0]   imm_ext, sra, alu;
   logic [W-1:0]   madd;
   logic [W:0]     msum;
   logic [W+1:0]   trial;
   logic [2*W-1:0] prod, prod_n;
   logic [W-1:0]   quo, rem;
   logic           unused_bits;

   assign c    = bus.Control;
   assign s1   = ~c[0] & bus.Op1[W-1];
   assign s2   = ~c[0] & bus.Op2[W-1];
   assign abs1 = s1 ? -bus.Op1 : bus.Op1;
   assign abs2 = s2 ? -bus.Op2 : bus.Op2;

   assign imm_ext = {{(W-IMMW){bus.Op2[IMMW-1]}},
                     bus.Op2[IMMW-1:0]};
   assign sra     = $unsigned($signed(bus.Op2) >>> bus.SA);

   // Disabled units contribute zero, enabled ones are OR-ed.
   assign alu =
        ({W{c[1]}} & (bus.Op1 + bus.Op2))
      | ({W{c[2]}} & (bus.Op1 - bus.Op2))
      | ({W{c[5]}} & (bus.Op1 & bus.Op2))
      | ({W{c[6]}} & (bus.Op1 | bus.Op2))
      | ({W{c[7]}} & ~(bus.Op1 | bus.Op2))
      | ({W{c[8]}} & (bus.Op1 ^ bus.Op2))
      | ({W{c[9]}} & (bus.Op2 << bus.SA))
      | ({W{c[10] | c[11]}} &
         (c[11] ? sra : bus.Op2 >> bus.SA))
      | ({W{c[13] | c[14]}} & (bus.Op1 + imm_ext));

   // Shift-add: add multiplicand on lo[0], shift {sum, lo} right.
   assign madd = lo_q[0] ? opb_q : {W{1'b0}};
   assign msum = {1'b0, hi_q} + {1'b0, madd};

   // Restoring step: MSB of trial is the borrow (no subtract).
   assign trial = {1'b0, hi_q, lo_q[W-1]} - {2'b00, opb_q};

   assign prod   = {hi_q, lo_q};
   assign prod_n = neg_q ? -prod : prod;
   assign quo    = dz_q ? {W{1'b1}} : (neg_q ? -lo_q : lo_q);
   assign rem    = negr_q ? -hi_q : hi_q;

   assign unused_bits = ^{c[30:15], c[12], trial[W]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      wb_d     = wb_q;
      dst_d    = dst_q;
      sv_d     = sv_q;
      ov_d     = 1'b0;
      wbo_d    = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      res_d    = res_q;
      hio_d    = hio_q;
      dsto_d   = dsto_q;
      svo_d    = svo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.InValid) begin
               if (c[3] | c[4]) begin
                  lo_d     = abs1;
                  opb_d    = abs2;
                  hi_d     = '0;
                  is_div_d = ~c[3];
                  neg_d    = s1 ^ s2;
                  negr_d   = s1;
                  dz_d     = ~c[3] & (bus.Op2 == '0);
                  wb_d     = c[31];
                  dst_d    = bus.DstIn;
                  sv_d     = bus.StoreValIn;
                  cnt_d    = SAW'(W - 1);
                  state_d  = c[3] ? MUL : DIV;
               end else begin
                  ov_d   = 1'b1;
                  res_d  = alu;
                  hio_d  = '0;
                  dsto_d = bus.DstIn;
                  svo_d  = bus.StoreValIn;
                  wbo_d  = c[31];
                  mr_d   = c[13];
                  mw_d   = c[14];
               end
            end
         end
         MUL: begin
            hi_d  = msum[W:1];
            lo_d  = {msum[0], lo_q[W-1:1]};
            cnt_d = cnt_q - SAW'(1);
            if (cnt_q == '0)
               state_d = FIN;
         end
         DIV: begin
            hi_d  = trial[W+1] ? {hi_q[W-2:0], lo_q[W-1]}
                               : trial[W-1:0];
            lo_d  = {lo_q[W-2:0], ~trial[W+1]};
            cnt_d = cnt_q - SAW'(1);
            if (cnt_q == '0)
               state_d = FIN;
         end
         FIN: begin
            ov_d    = 1'b1;
            wbo_d   = wb_q;
            dsto_d  = dst_q;
            svo_d   = sv_q;
            res_d   = is_div_q ? quo : prod_n[W-1:0];
            hio_d   = is_div_q ? rem : prod_n[2*W-1:W];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lo_q     <= '0;
         hi_q     <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         wb_q     <= 1'b0;
         dst_q    <= '0;
         sv_q     <= '0;
         ov_q     <= 1'b0;
         res_q    <= '0;
         hio_q    <= '0;
         dsto_q   <= '0;
         wbo_q    <= 1'b0;
         svo_q    <= '0;
         mr_q     <= 1'b0;
         mw_q     <= 1'b0;
      end else begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         wb_q     <= wb_d;
         dst_q    <= dst_d;
         sv_q     <= sv_d;
         ov_q     <= ov_d;
         res_q    <= res_d;
         hio_q    <= hio_d;
         dsto_q   <= dsto_d;
         wbo_q    <= wbo_d;
         svo_q    <= svo_d;
         mr_q     <= mr_d;
         mw_q     <= mw_d;
      end
   end

   assign bus.Stall         = (state_q != IDLE);
   assign bus.OutValid      = ov_q;
   assign bus.Result        = res_q;
   assign bus.HiOut         = hio_q;
   assign bus.DstOut        = dsto_q;
   assign bus.WriteBack     = wbo_q;
   assign bus.ExStoreValOut = svo_q;
   assign bus.isMemRead     = mr_q;
   assign bus.isMemWrite    = mw_q;
endmodule

// File: tb/tb_iex_multicycle.sv
// Directed bench for iex_multicycle: ALU ops, mul/div latency,
// sign handling, divide-by-zero, held issue and mid-op reset.
module tb_iex_multicycle;
   localparam logic [31:0] C_UNS = 32'h0000_0001;
   localparam logic [31:0] C_ADD = 32'h0000_0002;
   localparam logic [31:0] C_SUB = 32'h0000_0004;
   localparam logic [31:0] C_MUL = 32'h0000_0008;
   localparam logic [31:0] C_DIV = 32'h0000_0010;
   localparam logic [31:0] C_SLL = 32'h0000_0200;
   localparam logic [31:0] C_SRL = 32'h0000_0400;
   localparam logic [31:0] C_SRA = 32'h0000_0800;
   localparam logic [31:0] C_MW  = 32'h0000_4000;
   localparam logic [31:0] C_WB  = 32'h8000_0000;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad = 0;
   int   n;
   int   cnt;

   iex_multicycle_if bus ();

   iex_multicycle dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge Clk);
   endtask

   task automatic issue(input logic [31:0] ctl,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0]  sa,
                        input logic [4:0]  dst,
                        input logic [31:0] sv);
      bus.InValid    = 1'b1;
      bus.Control    = ctl;
      bus.Op1        = a;
      bus.Op2        = b;
      bus.SA         = sa;
      bus.DstIn      = dst;
      bus.StoreValIn = sv;
   endtask

   task automatic drain(output int k);
      k = 0;
      while (bus.Stall === 1'b1 && k < 100) begin
         k++;
         step();
      end
   endtask

   initial begin
      Reset = 1'b1;
      issue(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0);
      bus.InValid = 1'b0;
      step();
      step();
      chk("rst_stall", bus.Stall, 0);
      chk("rst_ov", bus.OutValid, 0);
      chk("rst_res", bus.Result, 0);
      chk("rst_wb", bus.WriteBack, 0);
      Reset = 1'b0;

      issue(C_ADD | C_WB, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd5, 32'h0);
      step();
      chk("add_res", bus.Result, 32'h0);
      chk("add_ov", bus.OutValid, 1);
      chk("add_dst", bus.DstOut, 5);
      chk("add_wb", bus.WriteBack, 1);
      chk("add_hi", bus.HiOut, 0);
      bus.InValid = 1'b0;
      step();
      chk("bub_ov", bus.OutValid, 0);
      chk("bub_wb", bus.WriteBack, 0);
      chk("bub_hold", bus.Result, 32'h0);

      issue(C_SRL | C_SRA, 32'h0, 32'h8000_0000, 5'd4, 5'd1, 32'h0);
      step();
      chk("sra", bus.Result, 32'hF800_0000);
      issue(C_SRL, 32'h0, 32'h8000_0000, 5'd4, 5'd1, 32'h0);
      step();
      chk("srl", bus.Result, 32'h0800_0000);
      issue(C_SLL, 32'h0, 32'h3, 5'd4, 5'd1, 32'h0);
      step();
      chk("sll", bus.Result, 32'h30);
      issue(C_SUB, 32'd5, 32'd7, 5'd0, 5'd1, 32'h0);
      step();
      chk("sub", bus.Result, 32'hFFFF_FFFE);

      issue(C_MUL | C_WB, 32'hFFFF_FFFD, 32'd7, 5'd0, 5'd7, 32'h0);
      step();
      bus.InValid = 1'b0;
      chk("mul_stall", bus.Stall, 1);
      chk("mul_bub", bus.OutValid, 0);
      drain(n);
      chk("mul_lat", n, 33);
      chk("mul_lo", bus.Result, 32'hFFFF_FFEB);
      chk("mul_hi", bus.HiOut, 32'hFFFF_FFFF);
      chk("mul_ov", bus.OutValid, 1);
      chk("mul_wb", bus.WriteBack, 1);
      chk("mul_dst", bus.DstOut, 7);
      chk("mul_mw", bus.isMemWrite, 0);

      issue(C_MUL | C_UNS, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd2, 32'h0);
      step();
      bus.InValid = 1'b0;
      drain(n);
      chk("umul_lo", bus.Result, 32'hFFFF_FFFE);
      chk("umul_hi", bus.HiOut, 32'h1);

      issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 5'd3, 32'h0);
      step();
      bus.InValid = 1'b0;
      drain(n);
      chk("div_lat", n, 33);
      chk("div_q", bus.Result, 32'hFFFF_FFFD);
      chk("div_r", bus.HiOut, 32'hFFFF_FFFF);

      issue(C_DIV, 32'd9, 32'd0, 5'd0, 5'd3, 32'h0);
      step();
      bus.InValid = 1'b0;
      drain(n);
      chk("dz_q", bus.Result, 32'hFFFF_FFFF);
      chk("dz_r", bus.HiOut, 32'd9);

      issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 5'd3, 32'h0);
      step();
      bus.InValid = 1'b0;
      drain(n);
      chk("min_q", bus.Result, 32'h8000_0000);
      chk("min_r", bus.HiOut, 32'h0);

      issue(C_MW, 32'h1000, 32'h0000_FFFC, 5'd0, 5'd0, 32'hAB);
      step();
      chk("mw_addr", bus.Result, 32'h0FFC);
      chk("mw_flag", bus.isMemWrite, 1);
      chk("mw_sv", bus.ExStoreValOut, 32'hAB);
      chk("mw_wb", bus.WriteBack, 0);

      issue(C_DIV | C_WB, 32'd100, 32'd7, 5'd0, 5'd4, 32'h0);
      step();
      issue(C_ADD | C_WB, 32'd2, 32'd3, 5'd0, 5'd9, 32'h0);
      chk("hold_mw", bus.isMemWrite, 0);
      chk("hold_ov", bus.OutValid, 0);
      drain(n);
      chk("hold_lat", n, 33);
      chk("d100_q", bus.Result, 32'd14);
      chk("d100_r", bus.HiOut, 32'd2);
      chk("d100_dst", bus.DstOut, 4);
      step();
      chk("held_res", bus.Result, 32'd5);
      chk("held_dst", bus.DstOut, 9);
      chk("held_ov", bus.OutValid, 1);
      bus.InValid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.OutValid === 1'b1)
            cnt++;
      end
      chk("held_once", cnt, 0);

      issue(C_MUL, 32'd3, 32'd4, 5'd0, 5'd6, 32'h0);
      step();
      bus.InValid = 1'b0;
      repeat (5) step();
      chk("mid_stall", bus.Stall, 1);
      Reset = 1'b1;
      step();
      step();
      chk("mr_stall", bus.Stall, 0);
      chk("mr_ov", bus.OutValid, 0);
      chk("mr_res", bus.Result, 0);
      chk("mr_hi", bus.HiOut, 0);
      chk("mr_dst", bus.DstOut, 0);
      chk("mr_sv", bus.ExStoreValOut, 0);
      Reset = 1'b0;
      issue(C_ADD, 32'd10, 32'd20, 5'd0, 5'd3, 32'h0);
      step();
      chk("pr_res", bus.Result, 32'd30);
      chk("pr_ov", bus.OutValid, 1);
      chk("pr_stall", bus.Stall, 0);
      bus.InValid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
